uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Serial UART receiver: 8N1 (optional 8E1), LSB first, mid-bit sampling from a baud counter.
//  Received bytes go into a small FIFO and leave on a valid/ready byte stream.
//  Slave-side peripheral companion of the SoC UART transmit path; it also drives the CPU's rx input in soc bring-up.
// PARAMETERS
//  CLKS_PER_BIT  868  clk_i cycles per bit (100 MHz / 115200 baud); must be >= 8
//  FIFO_DEPTH    4    receive FIFO entries; must be a power of 2, >= 2
// PORTS
//  clk_i          in   1  single system clock
//  rst_ni         in   1  asynchronous, active-low reset
//  rx_i           in   1  asynchronous serial input, idle high
//  rx_data_o      out  8  FIFO head byte
//  rx_valid_o     out  1  FIFO non-empty
//  rx_ready_i     in   1  consumer accepts head byte when rx_valid_o && rx_ready_i
//  frame_err_o    out  1  1-cycle pulse: stop bit sampled 0
//  overrun_err_o  out  1  1-cycle pulse: completed byte dropped, FIFO full
//  parity_err_o   out  1  1-cycle pulse: parity mismatch (constant 0 when feature is off)
//  busy_o         out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, FIFO empty, both sync flops =1, counters 0. Reset mid-frame aborts the frame and discards it.
//  - rx_i passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
//  - FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
//    - IDLE: on rx_s==0, go to START and clear the baud counter.
//    - START: at count CLKS_PER_BIT/2-1, sample. If 0, go to DATA and bit_idx=0. If 1 (glitch), go to IDLE with no error.
//    - DATA: every CLKS_PER_BIT cycles, sample the bit into shift[bit_idx] (LSB first). After bit 7, go to PARITY if enabled, else STOP.
//    - PARITY: after CLKS_PER_BIT cycles, sample. Mismatch sets a sticky flag for this frame.
//    - STOP: after CLKS_PER_BIT cycles, sample.
//      - Sample 1: push the byte (parity flag clear) and go to IDLE.
//      - Sample 0: pulse frame_err_o, discard the byte, go to BREAK.
//    - BREAK: wait for rx_s==1, then go to IDLE. No new start bit is detected while the line is held low.
//  - Parity failure: pulse parity_err_o in the STOP-sample cycle and do not push. frame_err_o has priority if both apply; only one pulse per frame.
//  - Latency: byte visible on rx_valid_o 1 cycle after the STOP sample. Input to sample: 2 sync cycles plus mid-bit offset.
//  - FIFO:
//    - Pointers wrap modulo FIFO_DEPTH. A count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
//    - Pop when rx_valid_o && rx_ready_i.
//    - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle (full + pop + push keeps count unchanged).
//    - Push into a full FIFO without a pop: byte dropped, overrun_err_o pulses, FIFO contents unchanged.
//    - Empty + push: rx_valid_o rises the next cycle. There is no combinational bypass.
//    - rx_data_o is stable while rx_valid_o && !rx_ready_i.
//  - Error pulses are registered, high for exactly 1 cycle. The FSM keeps running after any error.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - Frame is start, 8 data bits, even-parity bit, stop (11 bits).
//   - PARITY state present; parity_err_o is live.
//  Not defined:
//   - 8N1 framing (10 bits).
//   - PARITY state absent; parity_err_o tied to 0.
// TESTING (CLKS_PER_BIT=868, 10 ns clk, bit period 8680 ns)
//  1. Send 0x41 then 0x42 with rx_ready_i=1 -> rx_valid_o pulses twice; rx_data_o = 0x41 then 0x42; no error pulses.
//  2. rx_ready_i=0; send 5 bytes 0x01..0x05 (FIFO_DEPTH=4) -> 4 entries held; overrun_err_o pulses once on 0x05;
//     raising rx_ready_i drains 0x01..0x04 in order.
//  3. Drive rx_i low for 300 cycles, then high (glitch shorter than half a bit) -> no push, no error, busy_o returns to 0.
//  4. Send 0x55 with stop bit forced 0, hold line low for 20 bit times, then send 0xA5 ->
//     frame_err_o pulses once; only 0xA5 is received.
//  5. Assert rst_ni low during bit 4 of 0x3C, release, send 0xC3 ->
//     FIFO holds only 0xC3; all outputs 0 during reset.
//  6. (UART_RX_PARITY_EN) Send 0x07 with parity bit 0 (wrong; correct is 1) -> parity_err_o pulses, no push;
//     resend with correct parity -> 0x07 received.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined), LSB first,
// mid-bit sampling from a baud counter, feeding a small FIFO drained by a valid/ready stream.
//
// Optional feature macro: UART_RX_PARITY_EN (adds even-parity bit, PARITY state, live parity_err_o)
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   rx_i           asynchronous serial input, idle high
//   rx_data_o      FIFO head byte
//   rx_valid_o     FIFO non-empty
//   rx_ready_i     consumer accepts head byte when rx_valid_o && rx_ready_i
//   frame_err_o    1-cycle pulse: stop bit sampled 0
//   overrun_err_o  1-cycle pulse: completed byte dropped because the FIFO was full
//   parity_err_o   1-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//   busy_o         receiver FSM not idle
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
`ifdef UART_RX_PARITY_EN
    , StParity = 3'd5
`endif
  } state_e;

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx_i};
  end

  assign rx_s = sync_q[1];

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;
  logic          par_flag_q;
  logic          par_err_q;
  logic          stop_sample;
  logic          push;

  assign stop_sample = (state_q == StStop) && (cnt_q == BitLast);
  assign push        = stop_sample && rx_s && !par_flag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      par_flag_q  <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q    <= StData;
              bit_idx_q  <= '0;
              par_flag_q <= 1'b0;
            end else begin
              state_q <= StIdle;  // glitch, silently ignored
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q             <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_q      <= '0;
            par_flag_q <= rx_s ^ (^shift_q);  // even parity: data xor parity bit must be 0
            state_q    <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              par_err_q <= par_flag_q;
              state_q   <= StIdle;
            end else begin
              // Framing error wins over a parity error in the same frame.
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Receive FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          overrun_q;
  logic          full, pop, push_ok;

  assign full    = (count_q == FullCnt);
  assign pop     = rx_valid_o && rx_ready_i;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (push_ok) begin
        mem_q[wptr_q] <= shift_q;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rx_data_o     = mem_q[rptr_q];
  assign rx_valid_o    = (count_q != '0);
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_q;
  assign busy_o        = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o  = par_err_q;
`else
  assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes into a queue, a monitor
// pops and compares on every accepted byte and counts error-pulse cycles.
module tb_uart_rx_fifo;

  localparam int unsigned C = 32;  // shortened bit period keeps the run small
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b1;
  logic       frame_err_o, overrun_err_o, parity_err_o, busy_o;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_err_o(overrun_err_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int pop_cnt = 0, frame_cnt = 0, overrun_cnt = 0, parity_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample 1 time unit after the falling edge, once stimulus has settled.
  always begin
    @(negedge clk);
    #1;
    if (rst_ni) begin
      if (rx_valid_o && rx_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, rx_data_o}, 32'hFFFF_FFFF);
        else check("rx_data", {24'h0, rx_data_o}, {24'h0, exp_q.pop_front()});
      end
      if (frame_err_o)   frame_cnt++;
      if (overrun_err_o) overrun_cnt++;
      if (parity_err_o)  parity_cnt++;
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * int'(C)) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    rx_i = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_i = b[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    send_bits(b, 8);
`ifdef UART_RX_PARITY_EN
    rx_i = (^b) ^ bad_par;
    repeat (C) @(negedge clk);
`else
    if (bad_par) rx_i = 1'b1;
`endif
    rx_i = stop_bit;
    repeat (C) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int f0, o0, p0, n0;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {22'h0, rx_valid_o, rx_data_o, frame_err_o, overrun_err_o,
                            busy_o}, 32'h0);
    check("reset_parity", {31'h0, parity_err_o}, 32'h0);
    rst_ni = 1'b1;
    wait_bits(1);
    check("idle_busy", {31'h0, busy_o}, 32'h0);

    // 1: two bytes back to back, consumer ready
    n0 = pop_cnt;
    exp_q.push_back(8'h41); send_byte(8'h41, 1'b1, 1'b0);
    exp_q.push_back(8'h42); send_byte(8'h42, 1'b1, 1'b0);
    wait_bits(1);
    drain_wait();
    check("t1_pops", pop_cnt - n0, 2);
    check("t1_errors", frame_cnt + overrun_cnt + parity_cnt, 0);

    // 2: overrun with a stalled consumer
    rx_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= int'(D)) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0);
    end
    wait_bits(1);
    check("t2_overrun", overrun_cnt, 1);
    check("t2_valid_held", {31'h0, rx_valid_o}, 1);
    check("t2_head_stable", {24'h0, rx_data_o}, 32'h01);
    rx_ready_i = 1'b1;
    drain_wait();
    @(negedge clk);
    check("t2_empty", {31'h0, rx_valid_o}, 0);

    // 3: glitch shorter than half a bit
    n0 = pop_cnt; f0 = frame_cnt;
    rx_i = 1'b0;
    repeat (C / 4) @(negedge clk);
    rx_i = 1'b1;
    wait_bits(2);
    check("t3_busy", {31'h0, busy_o}, 0);
    check("t3_no_push", pop_cnt - n0, 0);
    check("t3_no_err", frame_cnt - f0, 0);

    // 4: framing error then line held low, then a good byte
    f0 = frame_cnt; n0 = pop_cnt;
    send_byte(8'h55, 1'b0, 1'b0);
    rx_i = 1'b0;
    wait_bits(20);
    check("t4_break_busy", {31'h0, busy_o}, 1);
    rx_i = 1'b1;
    wait_bits(1);
    exp_q.push_back(8'hA5); send_byte(8'hA5, 1'b1, 1'b0);
    wait_bits(1);
    drain_wait();
    check("t4_frame_err", frame_cnt - f0, 1);
    check("t4_pops", pop_cnt - n0, 1);

    // 5: reset in the middle of bit 4 of 0x3C
    send_bits(8'h3C, 4);
    rx_i = 1'b0;  // bit 4 of 0x3C is 1, but any level works for the abort
    rx_i = 1'b1;
    repeat (C / 2) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs", {22'h0, rx_valid_o, rx_data_o, frame_err_o, overrun_err_o,
                               busy_o}, 32'h0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    rx_i = 1'b1;
    wait_bits(2);
    check("t5_idle_after", {30'h0, busy_o, rx_valid_o}, 0);
    rx_ready_i = 1'b0;
    exp_q.push_back(8'hC3); send_byte(8'hC3, 1'b1, 1'b0);
    wait_bits(1);
    check("t5_head", {23'h0, rx_valid_o, rx_data_o}, 32'h1C3);
    rx_ready_i = 1'b1;
    drain_wait();
    @(negedge clk);
    check("t5_only_one", {31'h0, rx_valid_o}, 0);

`ifdef UART_RX_PARITY_EN
    // 6: wrong parity dropped, correct parity accepted
    p0 = parity_cnt; n0 = pop_cnt; f0 = frame_cnt;
    send_byte(8'h07, 1'b1, 1'b1);
    wait_bits(1);
    check("t6_parity_err", parity_cnt - p0, 1);
    check("t6_no_push", pop_cnt - n0, 0);
    exp_q.push_back(8'h07); send_byte(8'h07, 1'b1, 1'b0);
    wait_bits(1);
    drain_wait();
    check("t6_pops", pop_cnt - n0, 1);
    check("t6_no_frame", frame_cnt - f0, 0);
`else
    p0 = parity_cnt;
    check("parity_tied", p0, 0);
`endif

    o0 = overrun_cnt;
    check("final_overrun_total", o0, 1);
    check("final_scoreboard", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
